// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - state encoding and defaults shared by the UART transmit scheduler
package uart_sched_pkg;

  // FSM state codes
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = IDLE,
    ST_LOAD      = LOAD,
    ST_WAIT_BUSY = WAIT_BUSY,
    ST_WAIT_DONE = WAIT_DONE
  } sched_state_e;

  // Word address of the UART transmit data register on the CPU store path
  localparam int unsigned UDRT_ADDR = 23;

  localparam int unsigned DEF_DEPTH        = 4;
  localparam int unsigned DEF_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with fill count, shared by the UART TX and RX queues
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  // DEPTH is a power of two, so the pointers wrap on their own
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; empty slots are never read out
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - queues CPU UDRT stores and starts one UART frame per byte (option: UART_TX_SCHED_TIMEOUT_EN)
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
`ifdef UART_TX_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             stall,
  input  logic             uart_busy,
  output logic             uart_start,
  output logic [7:0]       uart_data,
  output logic [CNT_W-1:0] fifo_count,
  output logic             tx_idle,
  output logic             tx_err
);

  sched_state_e state_q, state_d;
  logic         uart_start_q, uart_start_d;
  logic [7:0]   uart_data_q, uart_data_d;
  logic         fifo_pop, fifo_push, fifo_full, fifo_empty;
  logic [7:0]   fifo_head;

  // The head leaves the queue during LOAD, which frees a slot for a store in that same cycle
  assign fifo_pop  = (state_q == ST_LOAD);
  assign stall     = wr_en && fifo_full && !fifo_pop;
  assign fifo_push = wr_en && !stall;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign uart_start = uart_start_q;
  assign uart_data  = uart_data_q;
  assign tx_idle    = (state_q == ST_IDLE) && fifo_empty;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       tx_err_q, tx_err_d;
  assign tx_err = tx_err_q;
`else
  assign tx_err = 1'b0;
`endif

  // Next-state, start pulse and data latch; start fires in the cycle after LOAD
  always_comb begin
    state_d      = state_q;
    uart_start_d = 1'b0;
    uart_data_d  = uart_data_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tx_err_d     = tx_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // An externally busy transmitter holds us off even with data queued
        if (!fifo_empty && !uart_busy) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        uart_data_d  = fifo_head;
        uart_start_d = 1'b1;
        state_d      = ST_WAIT_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        tmo_cnt_d    = '0;
`endif
      end
      ST_WAIT_BUSY: begin
        if (uart_busy) state_d = ST_WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Transmitter never acknowledged: drop the byte and flag it
        else if (tmo_cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          tx_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler registers; reset abandons any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      uart_start_q <= 1'b0;
      uart_data_q  <= 8'h00;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      tx_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      uart_start_q <= uart_start_d;
      uart_data_q  <= uart_data_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      tx_err_q     <= tx_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed and random checks of uart_tx_scheduler against a byte-queue model
module tb_uart_tx_scheduler;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       uart_busy = 1'b0;
  logic       stall, uart_start, tx_idle, tx_err;
  logic [7:0] uart_data;
  logic [2:0] fifo_count;

  uart_tx_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .stall      (stall),
    .uart_busy  (uart_busy),
    .uart_start (uart_start),
    .uart_data  (uart_data),
    .fifo_count (fifo_count),
    .tx_idle    (tx_idle),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Environment: UART busy window opened by each observed start pulse
  bit ext_busy = 0, uart_dead = 0, rand_uart = 0;
  int fr_d = 1, fr_len = 10;
  int bf = -1, bt = -2;
  logic [7:0] got[$];
  int last_start_cyc = -1;
  int peak = 0;
  logic stall_seen;

  // Reference model: queued bytes plus where the current byte is in its journey
  logic [7:0] mq[$];
  logic [7:0] acc[$];
  bit m_load, m_frame, m_seen, m_start, m_err;
  int m_wb;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_stall();
    return wr_en && (mq.size() == DEPTH) && !m_load;
  endfunction

  function automatic bit model_idle();
    return !m_load && !m_frame && (mq.size() == 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    acc.delete();
    m_load = 0; m_frame = 0; m_seen = 0; m_start = 0; m_err = 0;
    m_wb = 0; m_data = 8'h00;
  endtask

  task automatic model_edge();
    int sz0;
    bit st, nstart;
    sz0 = mq.size();
    st = exp_stall();
    nstart = 0;
    if (m_load) begin
      m_data = mq.pop_front();
      nstart = 1; m_load = 0; m_frame = 1; m_seen = 0; m_wb = 0;
    end else if (m_frame) begin
      if (!m_seen) begin
        if (uart_busy) m_seen = 1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        else begin
          m_wb++;
          if (m_wb == TMO) begin
            m_frame = 0;
            m_err = 1;
          end
        end
`endif
      end else if (!uart_busy) begin
        m_frame = 0;
      end
    end else if (sz0 != 0 && !uart_busy) begin
      m_load = 1;
    end
    if (wr_en && !st) begin
      mq.push_back(wr_data);
      acc.push_back(wr_data);
    end
    m_start = nstart;
  endtask

  task automatic step();
    int d, len;
    uart_busy = ext_busy || (cyc >= bf && cyc <= bt);
    #1;
    chk("stall", 32'(stall), 32'(exp_stall()));
    stall_seen = stall;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("uart_start", 32'(uart_start), 32'(m_start));
    chk("uart_data", 32'(uart_data), 32'(m_data));
    chk("tx_idle", 32'(tx_idle), 32'(model_idle()));
    chk("tx_err", 32'(tx_err), 32'(m_err));
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    if (uart_start === 1'b1) begin
      got.push_back(uart_data);
      last_start_cyc = cyc;
      chk("sb_nonempty", 32'(acc.size() != 0), 32'(1));
      if (acc.size() != 0) chk("sb_order", 32'(uart_data), 32'(acc.pop_front()));
      if (!uart_dead) begin
        d   = rand_uart ? int'($urandom_range(1, 3)) : fr_d;
        len = rand_uart ? int'($urandom_range(1, 6)) : fr_len;
        bf  = cyc + d;
        bt  = bf + len - 1;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 600 && !(model_idle() && cyc > bt); i++) step();
    chk({tag, "_bound"}, 32'(model_idle()), 32'(1));
    chk(tag, 32'(tx_idle), 32'(1));
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_start", 32'(uart_start), 32'(0));
    chk("rst_data", 32'(uart_data), 32'(0));
    chk("rst_idle", 32'(tx_idle), 32'(1));
    chk("rst_err", 32'(tx_err), 32'(0));
    model_reset();
    got.delete();
    bf = -1; bt = -2;
    ext_busy = 0;
    uart_busy = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int push_cyc, drop_cyc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("init_count", 32'(fifo_count), 32'(0));
    chk("init_start", 32'(uart_start), 32'(0));
    chk("init_data", 32'(uart_data), 32'(0));
    chk("init_idle", 32'(tx_idle), 32'(1));
    chk("init_err", 32'(tx_err), 32'(0));
    chk("init_stall", 32'(stall), 32'(0));
    model_reset();
    #2;
    rst = 1'b0;

    // T1: single byte, start two cycles after the push edge
    fr_d = 1; fr_len = 10;
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    push_cyc = cyc;
    wr_en = 1'b0;
    for (int i = 0; i < 10 && got.size() == 0; i++) step();
    chk("t1_started", 32'(got.size()), 32'(1));
    chk("t1_latency", 32'(last_start_cyc - push_cyc), 32'(2));
    chk("t1_data", 32'(uart_data), 32'(8'h41));
    repeat (12) step();
    chk("t1_idle_after", 32'(tx_idle), 32'(1));

    // T2/T3: fill while transmitter busy, fifth store stalls until the LOAD cycle
    got.delete();
    fr_len = 20;
    peak = 0;
    ext_busy = 1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(16 + i);
      step();
      chk("t2_accept", 32'(stall_seen), 32'(0));
    end
    wr_data = 8'h14;
    repeat (3) begin
      step();
      chk("t2_stall5", 32'(stall_seen), 32'(1));
    end
    ext_busy = 0;
    step();
    chk("t2_stall_idle", 32'(stall_seen), 32'(1));
    chk("t3_count_before", 32'(fifo_count), 32'(4));
    step();
    chk("t3_stall_load", 32'(stall_seen), 32'(0));
    chk("t3_count_after", 32'(fifo_count), 32'(4));
    wr_en = 1'b0;
    for (int i = 0; i < 400 && got.size() < 5; i++) step();
    chk("t2_nstarts", 32'(got.size()), 32'(5));
    for (int i = 0; i < got.size(); i++) chk("t2_order", 32'(got[i]), 32'(16 + i));
    chk("t2_peak", 32'(peak), 32'(4));
    wait_idle("t2_idle");

    // T6: externally busy transmitter in IDLE holds off the start
    got.delete();
    ext_busy = 1;
    wr_en = 1'b1; wr_data = 8'h66;
    step();
    wr_en = 1'b0;
    repeat (8) step();
    chk("t6_no_start", 32'(got.size()), 32'(0));
    chk("t6_count", 32'(fifo_count), 32'(1));
    ext_busy = 0;
    drop_cyc = cyc;
    for (int i = 0; i < 10 && got.size() == 0; i++) step();
    chk("t6_started", 32'(got.size()), 32'(1));
    chk("t6_latency", 32'(last_start_cyc - drop_cyc), 32'(2));
    wait_idle("t6_idle");

    // T5: transmitter never raises busy
    got.delete();
    uart_dead = 1;
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_data = 8'h5a;
    step();
    wr_en = 1'b0;
    repeat (45) step();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    chk("t5_err", 32'(tx_err), 32'(1));
    chk("t5_starts", 32'(got.size()), 32'(2));
    chk("t5_idle", 32'(tx_idle), 32'(1));
`else
    chk("t5_err", 32'(tx_err), 32'(0));
    chk("t5_starts", 32'(got.size()), 32'(1));
    chk("t5_stuck_count", 32'(fifo_count), 32'(1));
    chk("t5_not_idle", 32'(tx_idle), 32'(0));
`endif
    do_reset();
    uart_dead = 0;

    // T4: reset mid-frame with three bytes queued
    fr_d = 1; fr_len = 20;
    wr_en = 1'b1; wr_data = 8'h21;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 10 && got.size() == 0; i++) step();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(34 + i);
      step();
    end
    wr_en = 1'b0;
    repeat (2) step();
    chk("t4_queued", 32'(fifo_count), 32'(3));
    chk("t4_busy_frame", 32'(tx_idle), 32'(0));
    do_reset();
    repeat (10) step();
    chk("t4_no_start", 32'(got.size()), 32'(0));
    chk("t4_idle", 32'(tx_idle), 32'(1));

    // Random traffic against randomly sized frames
    rand_uart = 1;
    for (int i = 0; i < 500; i++) begin
      wr_en = ($urandom_range(0, 99) < 45);
      wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    wait_idle("rand_drain");
    chk("rand_sb_empty", 32'(acc.size()), 32'(0));
    chk("rand_some_starts", 32'(got.size() > 20), 32'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
